// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_D} rsp_sel_t;
    localparam logic [2:0] FUNCT3_WORD = 3'b010;
endpackage

// File: rtl/mem_arb_perf_cnt.sv
// mem_arb_perf_cnt: 32-bit wrapping event counter with enable.
module mem_arb_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and load/store, data first with bounded fetch starvation.
// Stall counters on perf_* exist only when MEM_ARBITER_PERF_EN is defined; otherwise they read 0.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4,
    parameter int STREAK_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_write_mem,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic [31:0] perf_if_stall,
    output logic [31:0] perf_d_stall
);
    logic [STREAK_W-1:0] streak;
    rsp_sel_t            rsp_sel;
    logic [31:0]         raddr_q;
    logic                force_if;
    logic                conc;
    logic                d_load;

    assign force_if = if_req && streak == STREAK_W'(MAX_DATA_STREAK);
    // A word store to a different word can share the cycle with a fetch: write and read ports are independent.
    assign conc   = d_req && d_we && d_funct3 == FUNCT3_WORD && if_req && d_addr[31:2] != if_addr[31:2];
    assign d_gnt  = rst_n && d_req && (!force_if || conc);
    assign if_gnt = rst_n && if_req && (!d_req || force_if || conc);
    assign d_load = d_gnt && !d_we;

    assign mem_write_mem     = d_gnt && d_we;
    assign mem_funct3        = d_gnt ? d_funct3 : FUNCT3_WORD;
    assign mem_write_address = d_addr;
    assign mem_write_data    = d_wdata;
    assign mem_read_address  = if_gnt ? if_addr : d_load ? d_addr : raddr_q;

    assign if_rvalid = rsp_sel == RSP_IF;
    assign d_rvalid  = rsp_sel == RSP_D;
    assign if_rdata  = if_rvalid ? mem_read_data : '0;
    assign d_rdata   = d_rvalid ? mem_read_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sel <= RSP_NONE;
            streak  <= '0;
            raddr_q <= '0;
        end else begin
            rsp_sel <= if_gnt ? RSP_IF : d_load ? RSP_D : RSP_NONE;
            raddr_q <= mem_read_address;
            streak  <= (!if_req || if_gnt) ? '0 :
                       (d_gnt && streak != STREAK_W'(MAX_DATA_STREAK)) ? streak + 1'b1 : streak;
        end
    end

`ifdef MEM_ARBITER_PERF_EN
    mem_arb_perf_cnt u_if_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (if_req && !if_gnt),
        .count (perf_if_stall)
    );
    mem_arb_perf_cnt u_d_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (d_req && !d_gnt),
        .count (perf_d_stall)
    );
`else
    assign perf_if_stall = '0;
    assign perf_d_stall  = '0;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus response scoreboard for mem_arbiter.
// Perf counter checks follow MEM_ARBITER_PERF_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        preload = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [2:0]  d_funct3 = 3'b010;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write_mem;
    logic [31:0] if_rdata, d_rdata, mem_write_address, mem_write_data, mem_read_address;
    logic [31:0] mem_read_data, perf_if_stall, perf_d_stall;
    logic [2:0]  mem_funct3;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
        .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
    );

    function automatic logic [31:0] init_val(input int i);
        return (i == 64) ? 32'hDEADBEEF : (32'hA500_0000 | i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] a,
                                          input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (f3[1:0])
            2'b00:   r[a*8 +: 8] = wd[7:0];
            2'b01:   r[a[1]*16 +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    // Memory model: synchronous write, read data registered one cycle after the address.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
        end else if (mem_write_mem) begin
            mem[mem_write_address[11:2]] <= merge(mem[mem_write_address[11:2]], mem_write_address[1:0],
                                                  mem_funct3, mem_write_data);
        end
        mem_read_data <= mem[mem_read_address[11:2]];
    end

    logic [31:0] ref_mem [0:1023];

    typedef struct {
        rsp_sel_t    kind;
        logic [31:0] data;
    } rsp_t;
    rsp_t sbq[$];

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [2:0]  f3;
        logic [31:0] da;
        logic [31:0] wd;
        logic        e_if;
        logic        e_d;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: check grants and port drive, queue the expected response, then check it after the edge.
    task automatic cyc(input logic e_if, input logic e_d);
        rsp_t r;
        #1;
        chk("if_gnt", if_gnt, e_if);
        chk("d_gnt", d_gnt, e_d);
        chk("mem_write_mem", mem_write_mem, e_d & d_we);
        if (e_if || e_d) chk("mem_funct3", mem_funct3, e_d ? {29'b0, d_funct3} : {29'b0, FUNCT3_WORD});
        if (e_if) begin
            r.kind = RSP_IF;
            r.data = ref_mem[if_addr[11:2]];
            chk("mem_read_address", mem_read_address, if_addr);
        end else if (e_d && !d_we) begin
            r.kind = RSP_D;
            r.data = ref_mem[d_addr[11:2]];
            chk("mem_read_address", mem_read_address, d_addr);
        end else begin
            r.kind = RSP_NONE;
            r.data = '0;
        end
        if (e_d && d_we) begin
            chk("mem_write_address", mem_write_address, d_addr);
            chk("mem_write_data", mem_write_data, d_wdata);
        end
        sbq.push_back(r);
        if (e_d && d_we) ref_mem[d_addr[11:2]] = merge(ref_mem[d_addr[11:2]], d_addr[1:0], d_funct3, d_wdata);
        @(posedge clk);
        #1;
        r = sbq.pop_front();
        chk("if_rvalid", if_rvalid, r.kind == RSP_IF);
        chk("d_rvalid", d_rvalid, r.kind == RSP_D);
        if (r.kind == RSP_IF) chk("if_rdata", if_rdata, r.data);
        if (r.kind == RSP_D) chk("d_rdata", d_rdata, r.data);
    endtask

    task automatic contend();
        if_req = 1'b1; if_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_funct3 = 3'b010; d_addr = 32'h104;
    endtask

    initial begin
        logic [31:0] p_if, p_d;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        //          ir  ia         dr  dw  f3  da         wd            e_if e_d
        tbl[0]  = '{0, 32'h000, 0, 0, 3'd2, 32'h000, 32'h0,        0, 0};
        tbl[1]  = '{1, 32'h100, 0, 0, 3'd2, 32'h000, 32'h0,        1, 0};
        tbl[2]  = '{1, 32'h100, 0, 0, 3'd2, 32'h000, 32'h0,        1, 0};
        tbl[3]  = '{1, 32'h100, 0, 0, 3'd2, 32'h000, 32'h0,        1, 0};
        tbl[4]  = '{0, 32'h000, 1, 0, 3'd2, 32'h104, 32'h0,        0, 1};
        tbl[5]  = '{1, 32'h204, 1, 1, 3'd2, 32'h200, 32'h12345678, 1, 1};
        tbl[6]  = '{0, 32'h000, 1, 0, 3'd2, 32'h200, 32'h0,        0, 1};
        tbl[7]  = '{1, 32'h100, 1, 1, 3'd0, 32'h201, 32'h000000AB, 0, 1};
        tbl[8]  = '{1, 32'h100, 0, 0, 3'd2, 32'h000, 32'h0,        1, 0};
        tbl[9]  = '{1, 32'h204, 1, 1, 3'd2, 32'h204, 32'hCAFEF00D, 0, 1};
        tbl[10] = '{1, 32'h204, 0, 0, 3'd2, 32'h000, 32'h0,        1, 0};
        tbl[11] = '{1, 32'h300, 1, 0, 3'd2, 32'h200, 32'h0,        0, 1};
        tbl[12] = '{1, 32'h300, 0, 0, 3'd2, 32'h000, 32'h0,        1, 0};
        tbl[13] = '{1, 32'h300, 1, 1, 3'd1, 32'h208, 32'h00005A5A, 0, 1};
        tbl[14] = '{0, 32'h000, 0, 0, 3'd2, 32'h000, 32'h0,        0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset if_rvalid", if_rvalid, 0);
        chk("reset d_rvalid", d_rvalid, 0);
        chk("reset mem_write_mem", mem_write_mem, 0);
        chk("reset perf_if_stall", perf_if_stall, 0);
        chk("reset perf_d_stall", perf_d_stall, 0);

        for (int i = 0; i < 15; i++) begin
            if_req = tbl[i].ir; if_addr = tbl[i].ia;
            d_req = tbl[i].dr; d_we = tbl[i].dw; d_funct3 = tbl[i].f3;
            d_addr = tbl[i].da; d_wdata = tbl[i].wd;
            cyc(tbl[i].e_if, tbl[i].e_d);
        end

        // Continuous load vs continuous fetch: four data grants, then a forced fetch.
        contend();
        p_if = perf_if_stall;
        p_d = perf_d_stall;
        for (int i = 0; i < 10; i++) begin
            cyc(i % 5 == 4, i % 5 != 4);
            if (i == 4) begin
`ifdef MEM_ARBITER_PERF_EN
                chk("perf_if_stall delta", perf_if_stall - p_if, 4);
                chk("perf_d_stall delta", perf_d_stall - p_d, 1);
`else
                chk("perf_if_stall off", perf_if_stall, 0);
                chk("perf_d_stall off", perf_d_stall, 0);
`endif
            end
        end

        // Reset with a load in flight and a partial streak.
        cyc(0, 1);
        cyc(0, 1);
        #1;
        chk("pre-reset d_gnt", d_gnt, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("in-reset d_rvalid", d_rvalid, 0);
        chk("in-reset mem_write_mem", mem_write_mem, 0);
        chk("in-reset d_gnt", d_gnt, 0);
        if_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset d_rvalid", d_rvalid, 0);
        chk("post-reset if_rvalid", if_rvalid, 0);
        chk("post-reset mem_write_mem", mem_write_mem, 0);
        contend();
        for (int i = 0; i < 5; i++) cyc(i == 4, i != 4);
        if_req = 1'b0;
        d_req = 1'b0;
        cyc(0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
